// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard decoder.
package ps2_pkg;
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} frame_state_t;
    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_F0 = 8'hF0;
    localparam logic [7:0] PFX_E1 = 8'hE1;
    localparam logic [7:0] DISC_AA = 8'hAA;
    localparam logic [7:0] DISC_FA = 8'hFA;
    localparam logic [7:0] DISC_FE = 8'hFE;
    localparam logic [7:0] DISC_EE = 8'hEE;
    localparam logic [7:0] DISC_00 = 8'h00;
    localparam logic [7:0] DISC_FF = 8'hFF;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;
    localparam int KEY_TOGGLE = 10;
    localparam int KEY_PRESSED = 9;
    localparam int KEY_EXT = 8;
    function automatic logic is_discard(input logic [7:0] b);
        return b inside {DISC_AA, DISC_FA, DISC_FE, DISC_EE, DISC_00, DISC_FF};
    endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 synchroniser, clock filter, timeout and frame FSM.
// PS2_PARITY_CHECK_EN defined enforces odd parity; otherwise parity is ignored.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 2048
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);
    localparam int CW = $clog2(TIMEOUT_CYC);
    logic [1:0] r_clk_sync, r_dat_sync;
    logic [FILTER_LEN-1:0] r_filt;
    logic r_clk_f, r_strobe;
    frame_state_t r_state, w_state_nx;
    logic [2:0] r_bit, w_bit_nx;
    logic [7:0] r_sr, w_sr_nx;
    logic r_par, w_par_nx;
    logic [CW-1:0] r_cnt;
    logic r_stop_err, w_stop_err_nx;
    logic w_dat, w_fall, w_timeout, w_par_ok;
    assign w_dat = r_dat_sync[1];
    assign w_fall = r_clk_f & ~|r_filt;
    // a strobe in the same cycle as expiry wins: the bit still lands
    assign w_timeout = (r_state != S_IDLE) && !r_strobe && (r_cnt == CW'(TIMEOUT_CYC - 1));
`ifdef PS2_PARITY_CHECK_EN
    assign w_par_ok = ^{r_sr, r_par};
`else
    assign w_par_ok = 1'b1 | r_par;
`endif
    assign o_byte = r_sr;
    assign o_byte_valid = r_strobe && (r_state == S_STOP) && w_dat && w_par_ok;
    assign o_frame_err = r_stop_err | w_timeout;
    always_comb begin
        w_state_nx = r_state;
        w_bit_nx = r_bit;
        w_sr_nx = r_sr;
        w_par_nx = r_par;
        w_stop_err_nx = 1'b0;
        if (w_timeout)
            w_state_nx = S_IDLE;
        else if (r_strobe)
            case (r_state)
                S_IDLE: begin
                    w_state_nx = w_dat ? S_IDLE : S_DATA;
                    w_bit_nx = 3'd0;
                end
                S_DATA: begin
                    w_sr_nx = {w_dat, r_sr[7:1]};
                    w_bit_nx = r_bit + 3'd1;
                    w_state_nx = (r_bit == 3'd7) ? S_PARITY : S_DATA;
                end
                S_PARITY: begin
                    w_par_nx = w_dat;
                    w_state_nx = S_STOP;
                end
                default: begin
                    w_stop_err_nx = ~(w_dat & w_par_ok);
                    w_state_nx = S_IDLE;
                end
            endcase
    end
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_filt <= '1;
            r_clk_f <= 1'b1;
            r_strobe <= 1'b0;
            r_state <= S_IDLE;
            r_bit <= '0;
            r_sr <= '0;
            r_par <= 1'b0;
            r_cnt <= '0;
            r_stop_err <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_data};
            r_filt <= {r_filt[FILTER_LEN-2:0], r_clk_sync[1]};
            r_clk_f <= (&r_filt) ? 1'b1 : (~|r_filt) ? 1'b0 : r_clk_f;
            r_strobe <= w_fall;
            r_state <= w_state_nx;
            r_bit <= w_bit_nx;
            r_sr <= w_sr_nx;
            r_par <= w_par_nx;
            r_stop_err <= w_stop_err_nx;
            r_cnt <= (r_strobe || r_state == S_IDLE) ? '0 :
                     (r_cnt == CW'(TIMEOUT_CYC - 1)) ? r_cnt : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 frames into {toggle, pressed, extended, code} key events.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 2048
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        frame_err
);
    logic w_byte_valid, w_frame_err;
    logic [7:0] w_byte;
    logic r_ext, r_brk, w_ext_nx, w_brk_nx;
    logic [2:0] r_skip, w_skip_nx;
    logic [10:0] r_key, w_key_nx;
    ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .i_ps2_clk   (ps2_clk_in),
        .i_ps2_data  (ps2_data_in),
        .o_byte_valid(w_byte_valid),
        .o_byte      (w_byte),
        .o_frame_err (w_frame_err)
    );
    assign ps2_key = r_key;
    assign frame_err = w_frame_err;
    always_comb begin
        w_ext_nx = r_ext;
        w_brk_nx = r_brk;
        w_skip_nx = r_skip;
        w_key_nx = r_key;
        if (w_frame_err) begin
            w_ext_nx = 1'b0;
            w_brk_nx = 1'b0;
            w_skip_nx = 3'd0;
        end else if (w_byte_valid) begin
            if (r_skip != 3'd0)
                w_skip_nx = r_skip - 3'd1;
            else if (w_byte == PFX_E0)
                w_ext_nx = 1'b1;
            else if (w_byte == PFX_F0)
                w_brk_nx = 1'b1;
            else if (w_byte == PFX_E1)
                w_skip_nx = PAUSE_SKIP;
            else begin
                w_ext_nx = 1'b0;
                w_brk_nx = 1'b0;
                w_key_nx = is_discard(w_byte) ? r_key : {~r_key[KEY_TOGGLE], ~r_brk, r_ext, w_byte};
            end
        end
    end
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
            r_skip <= 3'd0;
            r_key <= '0;
        end else begin
            r_ext <= w_ext_nx;
            r_brk <= w_brk_nx;
            r_skip <= w_skip_nx;
            r_key <= w_key_nx;
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed and randomized PS/2 key-event checks against an event-level model.
module tb_ps2_key_decoder;
    localparam int FL = 4;
    localparam int TO = 2048;
    localparam int H = 30;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pclk = 1'b1;
    logic pdat = 1'b1;
    logic [10:0] key;
    logic ferr;
    int n_chk = 0, n_fail = 0, n_err = 0, n_chg = 0, cyc = 0;
    int lat, t_fall;
    logic [10:0] key_q = '0;
    logic [10:0] exp_key = '0;
    always #5 clk = ~clk;
    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) u_dut (
        .clk_sys    (clk),
        .reset_n    (rst_n),
        .ps2_clk_in (pclk),
        .ps2_data_in(pdat),
        .ps2_key    (key),
        .frame_err  (ferr)
    );
    always @(negedge clk) begin
        cyc++;
        if (ferr === 1'b1) n_err++;
        if (key !== key_q) n_chg++;
        key_q = key;
    end
    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // bad[0] flips parity, bad[1] drives a 0 stop bit
    task automatic send_frame(input logic [7:0] b, input logic [1:0] bad, input int nbits, input int glitch_bit);
        logic [10:0] bits;
        logic [10:0] k0;
        bits = {~bad[1], ~^b ^ bad[0], b, 1'b0};
        k0 = key;
        lat = -1;
        for (int i = 0; i < nbits; i++) begin
            pdat = bits[i];
            repeat (H) @(negedge clk);
            if (i == glitch_bit) begin
                pclk = 1'b0;
                repeat (2) @(negedge clk);
                pclk = 1'b1;
                repeat (H) @(negedge clk);
            end
            pclk = 1'b0;
            t_fall = cyc;
            for (int k = 1; k <= H; k++) begin
                @(negedge clk);
                if (lat < 0 && (key !== k0 || ferr === 1'b1)) lat = k;
            end
            pclk = 1'b1;
        end
        pdat = 1'b1;
        repeat (H) @(negedge clk);
    endtask
    function automatic logic special(input logic [7:0] b);
        return b == 8'hE0 || b == 8'hF0 || b == 8'hE1 || b == 8'hAA || b == 8'hFA ||
               b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF;
    endfunction
    initial begin
        int c0, e0, t0, seen;
        logic [10:0] k0;
        logic [7:0] code, disc;
        logic mk, ex;
        logic [7:0] discs [6] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
        repeat (5) @(negedge clk);
        check("reset_key", 32'(key), 32'h0);
        check("reset_err", 32'(ferr), 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("release_no_event", 32'(n_chg + n_err), 32'h0);
        send_frame(8'h1C, 2'b00, 11, -1);
        check("make_1c", 32'(key), 32'h61C);
        check("latency", 32'(lat), 32'(FL + 4));
        check("no_err_1c", 32'(n_err), 32'h0);
        c0 = n_chg;
        send_frame(8'hE0, 2'b00, 11, -1);
        check("e0_silent", 32'(n_chg), 32'(c0));
        send_frame(8'hF0, 2'b00, 11, -1);
        check("f0_silent", 32'(n_chg), 32'(c0));
        send_frame(8'h75, 2'b00, 11, -1);
        check("break_ext_75", 32'(key), 32'h175);
        check("one_change", 32'(n_chg), 32'(c0 + 1));
        exp_key = 11'h175;
        e0 = n_err;
        k0 = key;
        send_frame(8'h29, 2'b01, 11, -1);
`ifdef PS2_PARITY_CHECK_EN
        check("par_err", 32'(n_err), 32'(e0 + 1));
        check("par_key_held", 32'(key), 32'(k0));
        check("par_err_latency", 32'(lat), 32'(FL + 4));
        send_frame(8'h29, 2'b00, 11, -1);
`endif
        exp_key = {~exp_key[10], 1'b1, 1'b0, 8'h29};
        check("make_29", 32'(key), 32'(exp_key));
        e0 = n_err;
        k0 = key;
        send_frame(8'hE0, 2'b00, 11, -1);
        send_frame(8'h42, 2'b10, 11, -1);
        check("stop_err", 32'(n_err), 32'(e0 + 1));
        check("stop_key_held", 32'(key), 32'(k0));
        check("stop_err_latency", 32'(lat), 32'(FL + 4));
        send_frame(8'h42, 2'b00, 11, -1);
        exp_key = {~exp_key[10], 1'b1, 1'b0, 8'h42};
        check("after_err_no_ext", 32'(key), 32'(exp_key));
        e0 = n_err;
        k0 = key;
        send_frame(8'h55, 2'b00, 6, -1);
        t0 = t_fall;
        seen = 0;
        for (int i = 0; i < 3000 && seen == 0; i++) begin
            @(negedge clk);
            if (ferr === 1'b1) seen = cyc;
        end
        check("timeout_seen", 32'(seen != 0), 32'h1);
        check("timeout_window", 32'((seen - t0) >= FL + 3 + TO - 8 && (seen - t0) <= FL + 3 + TO + 8), 32'h1);
        repeat (5) @(negedge clk);
        check("timeout_single", 32'(n_err), 32'(e0 + 1));
        check("timeout_key_held", 32'(key), 32'(k0));
        send_frame(8'h16, 2'b00, 11, -1);
        exp_key = {~exp_key[10], 1'b1, 1'b0, 8'h16};
        check("after_timeout_16", 32'(key), 32'(exp_key));
        c0 = n_chg;
        foreach (discs[i]) begin
            send_frame(8'hE1, 2'b00, 11, -1);
            break;
        end
        send_frame(8'h14, 2'b00, 11, -1);
        send_frame(8'h77, 2'b00, 11, -1);
        send_frame(8'hE1, 2'b00, 11, -1);
        send_frame(8'hF0, 2'b00, 11, -1);
        send_frame(8'h14, 2'b00, 11, -1);
        send_frame(8'hF0, 2'b00, 11, -1);
        send_frame(8'h77, 2'b00, 11, -1);
        check("pause_silent", 32'(n_chg), 32'(c0));
        send_frame(8'h16, 2'b00, 11, -1);
        exp_key = {~exp_key[10], 1'b1, 1'b0, 8'h16};
        check("after_pause_16", 32'(key), 32'(exp_key));
        check("pause_one_change", 32'(n_chg), 32'(c0 + 1));
        c0 = n_chg;
        e0 = n_err;
        pclk = 1'b0;
        repeat (2) @(negedge clk);
        pclk = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_glitch", 32'(n_chg + n_err), 32'(c0 + e0));
        send_frame(8'h3A, 2'b00, 11, 4);
        exp_key = {~exp_key[10], 1'b1, 1'b0, 8'h3A};
        check("frame_glitch_3a", 32'(key), 32'(exp_key));
        check("glitch_no_err", 32'(n_err), 32'(e0));
        send_frame(8'h33, 2'b00, 5, -1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_key", 32'(key), 32'h0);
        check("midreset_err", 32'(ferr), 32'h0);
        rst_n = 1'b1;
        exp_key = '0;
        repeat (10) @(negedge clk);
        send_frame(8'h1C, 2'b00, 11, -1);
        check("after_reset_1c", 32'(key), 32'h61C);
        exp_key = 11'h61C;
        e0 = n_err;
        for (int n = 0; n < 12; n++) begin
            do code = 8'($urandom_range(1, 254)); while (special(code));
            mk = 1'($urandom);
            ex = 1'($urandom);
            k0 = key;
            if ($urandom_range(0, 3) == 0) begin
                disc = discs[$urandom_range(0, 5)];
                send_frame(8'hE0, 2'b00, 11, -1);
                send_frame(disc, 2'b00, 11, -1);
                check("rand_discard_silent", 32'(key), 32'(k0));
            end
            if (ex) send_frame(8'hE0, 2'b00, 11, -1);
            if (!mk) send_frame(8'hF0, 2'b00, 11, -1);
            check("rand_prefix_silent", 32'(key), 32'(k0));
            send_frame(code, 2'b00, 11, -1);
            exp_key = {~exp_key[10], mk, ex, code};
            check("rand_event", 32'(key), 32'(exp_key));
        end
        check("rand_no_err", 32'(n_err), 32'(e0));
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
